// File: rtl/mem_port_arbiter.sv
// Shares memory port B between the CPU controller (read/write) and the VGA
// frame reader (read-only). The CPU has priority, but a wait counter forces a
// video grant once video has lost MAX_WAIT times in a row. Each read carries a
// registered (valid, owner) tag. The tag steers the returning word, one cycle
// later, to the requester that issued the read.
module mem_port_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 18,
    parameter int MAX_WAIT = 4     // legal range 1..15
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_dout,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_dout,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    logic              cpu_win;
    logic              vid_win;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              cpu_gnt_q, vid_gnt_q, busy_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_din_q;
    logic              tag_vld_q, tag_own_q;   // tag_own_q: 0 = CPU, 1 = video
    logic [DATA_W-1:0] cpu_dout_q, vid_dout_q;

    // Winner selection: the CPU wins unless video has been starved long enough.
    always_comb begin
        cpu_win    = 1'b0;
        vid_win    = 1'b0;
        wait_cnt_d = wait_cnt_q;
        if (cpu_req && !(vid_req && (wait_cnt_q >= 4'(MAX_WAIT)))) begin
            cpu_win = 1'b1;
        end else if (vid_req) begin
            vid_win = 1'b1;
        end
        if (vid_win) begin
            wait_cnt_d = 4'd0;
        end else if (vid_req && (wait_cnt_q != 4'hF)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // Issue stage: grant and memory command register together. The address and
    // write data hold their last values when the port is idle.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            cpu_gnt_q  <= 1'b0;
            vid_gnt_q  <= 1'b0;
            busy_q     <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            wait_cnt_q <= 4'd0;
        end else begin
            cpu_gnt_q  <= cpu_win;
            vid_gnt_q  <= vid_win;
            busy_q     <= cpu_win | vid_win;
            mem_we_q   <= cpu_win & cpu_we;
            wait_cnt_q <= wait_cnt_d;
            if (cpu_win) begin
                mem_addr_q <= cpu_addr;
                mem_din_q  <= cpu_din;
            end else if (vid_win) begin
                mem_addr_q <= vid_addr;
            end
        end
    end

    // Return stage: tag each read as it leaves the issue stage, and capture the
    // returned word so each owner's dout holds until that owner's next rvalid.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            tag_vld_q  <= 1'b0;
            tag_own_q  <= 1'b0;
            cpu_dout_q <= '0;
            vid_dout_q <= '0;
        end else begin
            tag_vld_q <= busy_q & ~mem_we_q;
            tag_own_q <= vid_gnt_q;
            if (cpu_rvalid) cpu_dout_q <= mem_dout;
            if (vid_rvalid) vid_dout_q <= mem_dout;
        end
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign vid_gnt    = vid_gnt_q;
    assign busy       = busy_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign cpu_rvalid = tag_vld_q & ~tag_own_q;
    assign vid_rvalid = tag_vld_q & tag_own_q;
    // The memory word is valid in the return cycle itself, so pass it straight
    // through while rvalid is high and hold the captured copy afterwards.
    assign cpu_dout   = cpu_rvalid ? mem_dout : cpu_dout_q;
    assign vid_dout   = vid_rvalid ? mem_dout : vid_dout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. A reference model issues expectations into
// queues at each rising edge. A monitor on the falling edge pops them and
// compares them against the DUT's outputs.
module tb_mem_port_arbiter;
    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 18;
    localparam int MAX_WAIT = 4;

    logic              CLK = 1'b0;
    logic              CLR = 1'b0;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_din = '0;
    logic              cpu_gnt, cpu_rvalid;
    logic [DATA_W-1:0] cpu_dout;
    logic              vid_req = 1'b0;
    logic [ADDR_W-1:0] vid_addr = '0;
    logic              vid_gnt, vid_rvalid;
    logic [DATA_W-1:0] vid_dout;
    logic              mem_we, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_rd = '0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .CLR(CLR),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_dout(cpu_dout),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid), .vid_dout(vid_dout),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_rd), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Memory attached to port B, plus the model's own view of its contents.
    logic [DATA_W-1:0] ram     [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];

    initial begin
        logic [DATA_W-1:0] rd_tmp;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ram[i]     = DATA_W'($urandom);
            ref_mem[i] = ram[i];
        end
        ram[14'h0010]     = 18'h2ABCD;
        ref_mem[14'h0010] = 18'h2ABCD;
        forever begin
            @(posedge CLK);
            rd_tmp = ram[mem_addr];
            if (mem_we) ram[mem_addr] = mem_din;
            mem_rd <= rd_tmp;
        end
    end

    typedef struct {
        int                cyc;
        int                own;    // 0 = CPU, 1 = video
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } iss_t;

    typedef struct {
        int                cyc;
        int                own;
        logic [DATA_W-1:0] data;
    } rd_t;

    iss_t              iss_q[$];
    rd_t               rd_q[$];
    int                cyc = 0;
    int                starve = 0;      // consecutive video losses
    logic [ADDR_W-1:0] last_addr = '0;
    logic [DATA_W-1:0] last_din  = '0;

    // Reference model: decides who is served at each edge and what comes back.
    initial begin
        forever begin
            @(posedge CLK or negedge CLR);
            if (!CLR) begin
                iss_q.delete();
                rd_q.delete();
                starve    = 0;
                last_addr = '0;
                last_din  = '0;
            end else begin
                cyc++;
                if (cpu_req || vid_req) begin
                    iss_t e;
                    bit   video_served;
                    video_served = vid_req && (!cpu_req || starve >= MAX_WAIT);
                    if (video_served) starve = 0;
                    else if (vid_req) starve = (starve < 15) ? starve + 1 : 15;
                    e.cyc = cyc;
                    if (video_served) begin
                        e.own = 1;
                        e.we  = 1'b0;
                        last_addr = vid_addr;
                    end else begin
                        e.own = 0;
                        e.we  = cpu_we;
                        last_addr = cpu_addr;
                        last_din  = cpu_din;
                    end
                    e.addr = last_addr;
                    e.din  = last_din;
                    iss_q.push_back(e);
                    if (e.we) begin
                        ref_mem[e.addr] = e.din;
                    end else begin
                        rd_t r;
                        r.cyc  = cyc + 1;
                        r.own  = e.own;
                        r.data = ref_mem[e.addr];
                        rd_q.push_back(r);
                    end
                end
            end
        end
    end

    logic [DATA_W-1:0] cpu_hold = '0;
    logic [DATA_W-1:0] vid_hold = '0;

    // Monitor: compares DUT outputs against queued expectations mid-cycle.
    initial begin
        forever begin
            @(negedge CLK);
            if (!CLR) begin
                check("reset_outputs",
                      {cpu_gnt, cpu_rvalid, cpu_dout, vid_gnt, vid_rvalid, vid_dout,
                       mem_we, mem_addr, mem_din, busy}, '0);
                cpu_hold = '0;
                vid_hold = '0;
            end else begin
                if (iss_q.size() > 0 && iss_q[0].cyc == cyc) begin
                    iss_t e;
                    e = iss_q.pop_front();
                    check("issue_gnt_busy", {cpu_gnt, vid_gnt, busy},
                          (e.own == 1) ? 3'b011 : 3'b101);
                    check("issue_we",   mem_we,   e.we);
                    check("issue_addr", mem_addr, e.addr);
                    check("issue_din",  mem_din,  e.din);
                end else begin
                    check("idle_ctl",  {cpu_gnt, vid_gnt, busy, mem_we}, 4'b0000);
                    check("idle_addr", mem_addr, last_addr);
                    check("idle_din",  mem_din,  last_din);
                end
                if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                    rd_t r;
                    r = rd_q.pop_front();
                    if (r.own == 0) begin
                        check("cpu_read_return", {cpu_rvalid, vid_rvalid, cpu_dout, vid_dout},
                              {2'b10, r.data, vid_hold});
                        cpu_hold = r.data;
                    end else begin
                        check("vid_read_return", {cpu_rvalid, vid_rvalid, cpu_dout, vid_dout},
                              {2'b01, cpu_hold, r.data});
                        vid_hold = r.data;
                    end
                end else begin
                    check("no_return", {cpu_rvalid, vid_rvalid, cpu_dout, vid_dout},
                          {2'b00, cpu_hold, vid_hold});
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] din);
        int k;
        cpu_req  = 1'b1;
        cpu_we   = we;
        cpu_addr = addr;
        cpu_din  = din;
        k = 0;
        do begin
            tick();
            k++;
        end while (!cpu_gnt && k < 20);
        if (!cpu_gnt) check("cpu_gnt_timeout", cpu_gnt, 1'b1);
        cpu_req = 1'b0;
    endtask

    logic [ADDR_W-1:0] vid_next = '0;

    task automatic run_cycles(input int n, input int unsigned cpu_pct,
                              input int unsigned vid_pct, input bit vid_seq);
        for (int i = 0; i < n; i++) begin
            if (!cpu_req || cpu_gnt) begin
                if ($urandom_range(99) < cpu_pct) begin
                    cpu_req  = 1'b1;
                    cpu_we   = 1'($urandom_range(1));
                    cpu_addr = ADDR_W'($urandom_range(63));
                    cpu_din  = DATA_W'($urandom);
                end else begin
                    cpu_req = 1'b0;
                end
            end
            if (!vid_req || vid_gnt) begin
                if ($urandom_range(99) < vid_pct) begin
                    vid_req = 1'b1;
                    if (vid_seq) begin
                        vid_addr = vid_next;
                        vid_next = vid_next + 1'b1;
                    end else begin
                        vid_addr = ADDR_W'($urandom_range(63));
                    end
                end else begin
                    vid_req = 1'b0;
                end
            end
            tick();
        end
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #3 CLR = 1'b1;
        tick();

        // CPU read of the preloaded word, then write/readback.
        cpu_access(1'b0, 14'h0010, '0);
        repeat (3) tick();
        cpu_access(1'b1, 14'h0020, 18'h00155);
        tick();
        cpu_access(1'b0, 14'h0020, '0);
        repeat (3) tick();

        // Contention: CPU requests every cycle while video stays pending.
        run_cycles(16, 100, 100, 1'b0);
        cpu_req = 1'b0;
        vid_req = 1'b0;
        repeat (3) tick();

        // Back-to-back video reads from 0x100.
        vid_next = 14'h0100;
        run_cycles(3, 0, 100, 1'b1);
        vid_req = 1'b0;
        repeat (4) tick();

        // Reset while a CPU read is in flight.
        cpu_access(1'b0, 14'h0010, '0);
        #2 CLR = 1'b0;
        tick();
        tick();
        #2 CLR = 1'b1;
        tick();
        cpu_access(1'b0, 14'h0021, '0);
        repeat (3) tick();

        // Idle stretch.
        repeat (10) tick();

        // Random mixed traffic.
        run_cycles(400, 50, 40, 1'b0);
        run_cycles(200, 90, 90, 1'b0);
        cpu_req = 1'b0;
        vid_req = 1'b0;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
